// File: rtl/gamma_lut_ctrl.sv
// Runtime-programmable gamma stage: two 256-entry banks, the pixel path reads the active one.
// The config loader fills the shadow bank, which becomes active only at a picture boundary.
module gamma_lut_ctrl #(
    parameter int COLOR_DEPTH = 8,
    parameter int COLOR_BITS  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COLOR_DEPTH-1:0] pixel_in,
    input  logic                   valid_in,
    input  logic [COLOR_BITS-1:0]  color_in,
    input  logic                   last_pic_in,
    output logic [COLOR_DEPTH-1:0] pixel_out,
    output logic                   valid_out,
    output logic [COLOR_BITS-1:0]  color_out,
    output logic                   last_pic_out,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic [COLOR_DEPTH-1:0] cfg_data,
    output logic                   cfg_ready,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   bypass
);

    // state | meaning
    // IDLE  | no load in progress, active bank in use
    // LOAD  | accepting table entries into the shadow bank
    // PEND  | shadow bank full, waiting for a picture boundary to swap
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PEND} state_t;

    localparam int DEPTH = 1 << COLOR_DEPTH;

    state_t                 r_state;
    logic [COLOR_DEPTH-1:0] r_wr_addr;
    logic                   r_active_bank;
    logic                   r_bypass;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_stream_active;

    logic [COLOR_DEPTH-1:0] r_lut [0:2*DEPTH-1];

    logic [COLOR_DEPTH-1:0] r_pix1;
    logic                   r_val1;
    logic [COLOR_BITS-1:0]  r_col1;
    logic                   r_last1;
    logic [COLOR_DEPTH-1:0] r_pix2;
    logic                   r_val2;
    logic [COLOR_BITS-1:0]  r_col2;
    logic                   r_last2;

    logic                   w_wr_en;
    logic [COLOR_DEPTH-1:0] w_wr_idx;
    logic                   w_swap_evt;

    // A restart that carries data writes it as entry 0 of the new table.
    assign w_wr_en    = cfg_valid & (cfg_start | (r_state == ST_LOAD));
    assign w_wr_idx   = cfg_start ? '0 : r_wr_addr;
    assign w_swap_evt = (r_val1 & r_last1) | ~r_stream_active;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_lut[{~r_active_bank, w_wr_idx}] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix1          <= '0;
            r_val1          <= 1'b0;
            r_col1          <= '0;
            r_last1         <= 1'b0;
            r_pix2          <= '0;
            r_val2          <= 1'b0;
            r_col2          <= '0;
            r_last2         <= 1'b0;
            r_stream_active <= 1'b0;
        end else begin
            r_pix1  <= pixel_in;
            r_val1  <= valid_in;
            r_col1  <= color_in;
            r_last1 <= last_pic_in;
            r_pix2  <= r_bypass ? r_pix1 : r_lut[{r_active_bank, r_pix1}];
            r_val2  <= r_val1;
            r_col2  <= r_col1;
            r_last2 <= r_last1;
            if (r_val1) begin
                r_stream_active <= ~r_last1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wr_addr     <= '0;
            r_active_bank <= 1'b0;
            r_bypass      <= 1'b1;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (cfg_start) begin
                r_state   <= ST_LOAD;
                r_ready   <= 1'b1;
                r_busy    <= 1'b1;
                r_wr_addr <= cfg_valid ? COLOR_DEPTH'(1) : '0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (cfg_valid) begin
                            r_wr_addr <= r_wr_addr + 1'b1;
                            if (r_wr_addr == '1) begin
                                r_state <= ST_PEND;
                                r_ready <= 1'b0;
                            end
                        end
                    end
                    ST_PEND: begin
                        if (w_swap_evt) begin
                            r_active_bank <= ~r_active_bank;
                            r_bypass      <= 1'b0;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign pixel_out    = r_pix2;
    assign valid_out    = r_val2;
    assign color_out    = r_col2;
    assign last_pic_out = r_last2;
    assign cfg_ready    = r_ready;
    assign cfg_busy     = r_busy;
    assign cfg_done     = r_done;
    assign bypass       = r_bypass;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Directed bench for gamma_lut_ctrl: bypass path, table loads, picture-boundary swap,
// load gaps, load restart and reset while a swap is pending.
module tb_gamma_lut_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] pixel_in;
    logic       valid_in;
    logic [1:0] color_in;
    logic       last_pic_in;
    logic [7:0] pixel_out;
    logic       valid_out;
    logic [1:0] color_out;
    logic       last_pic_out;
    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_busy;
    logic       cfg_done;
    logic       bypass;

    int vectors = 0;
    int fails   = 0;

    gamma_lut_ctrl #(.COLOR_DEPTH(8), .COLOR_BITS(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .valid_in     (valid_in),
        .color_in     (color_in),
        .last_pic_in  (last_pic_in),
        .pixel_out    (pixel_out),
        .valid_out    (valid_out),
        .color_out    (color_out),
        .last_pic_out (last_pic_out),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .bypass       (bypass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table patterns: 0 = 255-i, 1 = identity, 2 = i^FF, 3 = 7i+5, 4 = i^5A
    function automatic logic [7:0] tbl(input int mode, input int i);
        case (mode)
            0:       return 8'(255 - i);
            1:       return 8'(i);
            2:       return 8'(i ^ 255);
            3:       return 8'(i * 7 + 5);
            default: return 8'(i ^ 'h5A);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input string name, input logic [7:0] pix, input logic [1:0] col,
                              input logic last, input logic [7:0] exp);
        pixel_in    = pix;
        color_in    = col;
        last_pic_in = last;
        valid_in    = 1'b1;
        tick();
        valid_in    = 1'b0;
        last_pic_in = 1'b0;
        vectors++;
        if (valid_out !== 1'b0) begin
            $display("FAIL %s_early: valid_out=%b after 1 cycle, need 0", name, valid_out);
            fails++;
        end
        tick();
        vectors++;
        if ({valid_out, color_out, last_pic_out, pixel_out} !== {1'b1, col, last, exp}) begin
            $display("FAIL %s: got v=%b c=%0d l=%b px=%0d, need v=1 c=%0d l=%b px=%0d",
                     name, valid_out, color_out, last_pic_out, pixel_out, col, last, exp);
            fails++;
        end
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic write_range(input int mode, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                cfg_valid = 1'b0;
                cfg_data  = 8'hAA;
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = tbl(mode, i);
            vectors++;
            if ({cfg_ready, cfg_busy, cfg_done} !== 3'b110) begin
                $display("FAIL load_hs[%0d]: got rdy/busy/done=%b, need 110", i,
                         {cfg_ready, cfg_busy, cfg_done});
                fails++;
            end
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    // Stream idle: the swap follows the last write by exactly one cycle.
    task automatic expect_swap_next(input string name);
        vectors++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b010) begin
            $display("FAIL %s_pend: got rdy/busy/done=%b, need 010", name,
                     {cfg_ready, cfg_busy, cfg_done});
            fails++;
        end
        tick();
        vectors++;
        if ({cfg_done, bypass, cfg_busy} !== 3'b100) begin
            $display("FAIL %s_swap: got done/bypass/busy=%b, need 100", name,
                     {cfg_done, bypass, cfg_busy});
            fails++;
        end
        tick();
        vectors++;
        if (cfg_done !== 1'b0) begin
            $display("FAIL %s_donepulse: got done=%b, need 0", name, cfg_done);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({pixel_out, valid_out, color_out, last_pic_out, cfg_ready, cfg_busy, cfg_done, bypass}
            !== {8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_outputs: got px=%0d v=%b c=%0d l=%b rdy=%b busy=%b done=%b byp=%b, need all 0, byp=1",
                     pixel_out, valid_out, color_out, last_pic_out, cfg_ready, cfg_busy, cfg_done, bypass);
            fails++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        send_pixel("byp_0",   8'd0,   2'd1, 1'b0, 8'd0);
        send_pixel("byp_128", 8'd128, 2'd2, 1'b0, 8'd128);
        send_pixel("byp_255", 8'd255, 2'd3, 1'b1, 8'd255);
        vectors++;
        if (bypass !== 1'b1) begin
            $display("FAIL byp_flag: got %b, need 1", bypass);
            fails++;
        end
    endtask

    task automatic test_load_idle();
        start_load();
        write_range(0, 0, 255, 1'b0);
        expect_swap_next("idle_load");
        send_pixel("inv_10", 8'd10, 2'd0, 1'b1, 8'd245);
    endtask

    task automatic test_swap_mid_picture();
        start_load();
        write_range(1, 0, 255, 1'b0);
        expect_swap_next("ident_load");
        fork
            begin
                start_load();
                write_range(2, 0, 255, 1'b0);
            end
            begin
                repeat (200) tick();
                for (int k = 0; k <= 100; k++) begin
                    if (k < 100) begin
                        pixel_in    = 8'(k);
                        color_in    = 2'(k);
                        valid_in    = 1'b1;
                        last_pic_in = (k == 99);
                    end else begin
                        valid_in    = 1'b0;
                        last_pic_in = 1'b0;
                    end
                    tick();
                    if (k >= 1) begin
                        vectors++;
                        if ({valid_out, pixel_out, cfg_done} !== {1'b1, 8'(k - 1), (k == 100)}) begin
                            $display("FAIL pic_px[%0d]: got v=%b px=%0d done=%b, need v=1 px=%0d done=%b",
                                     k - 1, valid_out, pixel_out, cfg_done, k - 1, (k == 100));
                            fails++;
                        end
                    end
                end
            end
        join
        vectors++;
        if ({cfg_busy, bypass} !== 2'b00) begin
            $display("FAIL pic_swapped: got busy/byp=%b, need 00", {cfg_busy, bypass});
            fails++;
        end
        send_pixel("next_pic_3", 8'd3, 2'd1, 1'b1, 8'd252);
    endtask

    task automatic test_gaps();
        start_load();
        write_range(3, 0, 255, 1'b1);
        expect_swap_next("gap_load");
        send_pixel("gap_0",   8'd0,   2'd0, 1'b1, 8'd5);
        send_pixel("gap_127", 8'd127, 2'd1, 1'b1, 8'd126);
        send_pixel("gap_255", 8'd255, 2'd2, 1'b1, 8'd254);
    endtask

    task automatic test_restart();
        start_load();
        write_range(1, 0, 99, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = tbl(4, 0);
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        write_range(4, 1, 254, 1'b0);
        vectors++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b110) begin
            $display("FAIL restart_still_loading: got rdy/busy/done=%b, need 110",
                     {cfg_ready, cfg_busy, cfg_done});
            fails++;
        end
        send_pixel("restart_old_127", 8'd127, 2'd3, 1'b1, 8'd126);
        write_range(4, 255, 255, 1'b0);
        expect_swap_next("restart_load");
        send_pixel("restart_0",   8'd0,   2'd0, 1'b1, 8'd90);
        send_pixel("restart_100", 8'd100, 2'd1, 1'b1, 8'd62);
        send_pixel("restart_255", 8'd255, 2'd2, 1'b1, 8'd165);
    endtask

    task automatic test_reset_pending();
        send_pixel("open_pic_1", 8'd1, 2'd2, 1'b0, 8'd91);
        start_load();
        write_range(1, 0, 255, 1'b0);
        tick();
        vectors++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b010) begin
            $display("FAIL held_pend: got rdy/busy/done=%b, need 010", {cfg_ready, cfg_busy, cfg_done});
            fails++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pixel_out, valid_out, color_out, last_pic_out, cfg_ready, cfg_busy, cfg_done, bypass}
            !== {8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL async_reset: got px=%0d v=%b c=%0d l=%b rdy=%b busy=%b done=%b byp=%b, need all 0, byp=1",
                     pixel_out, valid_out, color_out, last_pic_out, cfg_ready, cfg_busy, cfg_done, bypass);
            fails++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_pixel("post_reset_77", 8'd77, 2'd3, 1'b1, 8'd77);
        vectors++;
        if ({cfg_busy, bypass} !== 2'b01) begin
            $display("FAIL post_reset_flags: got busy/byp=%b, need 01", {cfg_busy, bypass});
            fails++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_in    = '0;
        valid_in    = 1'b0;
        color_in    = '0;
        last_pic_in = 1'b0;
        cfg_start   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = '0;
        test_reset();
        test_bypass();
        test_load_idle();
        test_swap_mid_picture();
        test_gaps();
        test_restart();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/gamma_lut_ctrl.md
Name: gamma_lut_ctrl

Overview:
- Runtime-programmable gamma stage.
- Holds two 256x8 lookup banks: an active bank that the pixel stream reads and a shadow bank that a config loader writes.
- Sequences loading of the shadow bank and swaps the banks at a picture boundary, so a picture never mixes two curves.
- Sits in the pixel pipeline in place of a fixed gamma stage, with the same 2-cycle pixel latency and sideband passthrough.

Parameters:
- COLOR_DEPTH, 8, pixel width; LUT depth is 2^COLOR_DEPTH.
- COLOR_BITS, 2, width of the color tag sideband.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pixel_in  in  COLOR_DEPTH  input pixel
- valid_in  in  1  pixel_in qualifier
- color_in  in  COLOR_BITS  color tag
- last_pic_in  in  1  marks the final pixel of a picture when valid_in=1
- pixel_out  out  COLOR_DEPTH  gamma-mapped pixel
- valid_out  out  1  pixel_out qualifier
- color_out  out  COLOR_BITS  delayed color tag
- last_pic_out  out  1  delayed last_pic_in
- cfg_start  in  1  1-cycle pulse; begin a new table load at index 0
- cfg_valid  in  1  cfg_data qualifier
- cfg_data  in  COLOR_DEPTH  next table entry, index order 0..255
- cfg_ready  out  1  loader accepts cfg_data this cycle
- cfg_busy  out  1  load in progress or swap pending
- cfg_done  out  1  1-cycle pulse in the cycle the new table becomes active
- bypass  out  1  1 = no table loaded yet; pixels pass through unchanged

Behaviour:
- Clock and reset: single clock clk, posedge. rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except bypass=1. active_bank=0, FSM=IDLE, wr_addr=0, stream_active=0. LUT contents are not reset and are don't-care while bypass=1.
- Pixel pipeline stage 1: registers pixel_in, valid_in, color_in and last_pic_in unconditionally every cycle.
- Pixel pipeline stage 2: pixel_out <= bypass ? pixel_in_reg : LUT[active_bank][pixel_in_reg]. valid, color and last_pic are copied from stage 1.
- Latency: exactly 2 cycles, input to output. No backpressure on the pixel path. Outputs are registered even when valid=0.
- stream_active: set when valid_in_reg=1 and last_pic_in_reg=0. Cleared when valid_in_reg=1 and last_pic_in_reg=1.
- FSM IDLE: cfg_ready=0, cfg_busy=0. cfg_start -> LOAD with wr_addr=0.
- FSM LOAD: cfg_ready=1, cfg_busy=1. Each cycle with cfg_valid=1 writes shadow[wr_addr] (shadow = ~active_bank) and increments wr_addr. A write with wr_addr=255 -> PEND. cfg_valid while cfg_ready=0 is ignored (no write).
- FSM PEND: cfg_ready=0, cfg_busy=1. swap_evt = (valid_in_reg & last_pic_in_reg) | ~stream_active. On swap_evt: active_bank toggles, bypass<=0, cfg_done=1 for 1 cycle, -> IDLE.
- Swap timing: the last pixel of a picture, evaluated in stage 2 during the swap_evt cycle, uses the old bank. The first pixel reaching stage 2 the next cycle uses the new bank.
- cfg_start in LOAD or PEND aborts the current load and returns to LOAD with wr_addr=0. A pending swap is cancelled. The active bank is untouched.
- cfg_start and cfg_valid in the same cycle: the restart wins; the data is written to index 0 and wr_addr becomes 1.
- Writes go only to the shadow bank, so there is never a read/write conflict with the pixel path.
- Reset mid-load or mid-pending: all load progress is lost, bypass=1, FSM=IDLE.

Test Plan:
- Reset, no load; pixels 0, 128, 255 with valid_in=1 -> pixel_out 0, 128, 255 two cycles later; bypass=1; color and last_pic delayed by 2.
- With the stream idle: cfg_start, then 256 writes of data=255-i -> cfg_ready high for 256 accepted writes. After the last write, PEND swaps on the next cycle; cfg_done pulses and bypass=0. Pixel 10 -> 245.
- Swap mid-picture: load an identity table, then load table 2 (data=i^8'hFF) while a 100-pixel picture streams. The swap waits for the last_pic pixel; the pixels of that picture all use identity. The first pixel of the next picture, 3, maps to 252.
- Load with cfg_valid gaps (toggling every other cycle) -> exactly 256 writes are counted; the table is correct at indices 0, 127, 255.
- cfg_start at write 100 of a load -> restart at index 0; the active table is unchanged, and cfg_done pulses only after a full 256-write load.
- rst_n asserted during PEND -> all outputs clear asynchronously, bypass=1, cfg_busy=0; pixel 77 -> 77.
